// File: rtl/exc_irq_ctrl.sv
// Exception/interrupt sequencer for the 5-stage pipeline: prioritises EX/ID
// exceptions and synchronised IRQs, flushes, saves EPC/cause and runs ERET.
module exc_irq_ctrl #(
  parameter logic [31:0] EXC_VEC = 32'd400,
  parameter int unsigned IRQ_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IRQ_W-1:0] irq,
  input  logic [IRQ_W-1:0] irq_mask,
  input  logic             id_valid,
  input  logic             id_stall,
  input  logic [31:0]      pc_id,
  input  logic [31:0]      pc_ex,
  input  logic             exc_ovf,
  input  logic             exc_divz,
  input  logic             exc_brk,
  input  logic             exc_ri,
  input  logic             eret,
  output logic             flush_if,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic [31:0]      epc,
  output logic [2:0]       cause,
  output logic             exl,
  output logic [IRQ_W-1:0] irq_ack,
  output logic             double_fault
);

  typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_HANDLER, S_RETURN} state_t;

  localparam logic [2:0] C_IRQ  = 3'd1;
  localparam logic [2:0] C_OVF  = 3'd2;
  localparam logic [2:0] C_DIVZ = 3'd3;
  localparam logic [2:0] C_BRK  = 3'd4;
  localparam logic [2:0] C_RI   = 3'd5;

  state_t           state_q, state_d;
  logic [31:0]      epc_q, epc_d;
  logic [2:0]       cause_q, cause_d;
  logic             exl_q, exl_d;
  logic             df_q, df_d;
  logic [IRQ_W-1:0] sync1_q, sync2_q, prev_q;
  logic [IRQ_W-1:0] pend_q, pend_d;
  logic [IRQ_W-1:0] irq_rise, irq_avail, irq_sel;
  logic             ex_exc, id_exc, sel_found;

  assign irq_rise  = sync2_q & ~prev_q;
  assign irq_avail = pend_q & irq_mask;
  assign ex_exc    = exc_ovf | exc_divz;
  assign id_exc    = exc_ri | exc_brk | eret;

  // Lowest-index enabled pending line.
  always_comb begin
    irq_sel   = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < IRQ_W; i++) begin
      if (irq_avail[i] && !sel_found) begin
        irq_sel[i] = 1'b1;
        sel_found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    epc_d       = epc_q;
    cause_d     = cause_q;
    exl_d       = exl_q;
    df_d        = df_q;
    flush_if    = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = EXC_VEC;
    irq_ack     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (ex_exc) begin
          flush_if = 1'b1;
          flush_id = 1'b1;
          flush_ex = 1'b1;
          epc_d    = pc_ex;
          cause_d  = exc_ovf ? C_OVF : C_DIVZ;
          exl_d    = 1'b1;
          state_d  = S_REDIRECT;
        end else if (id_exc) begin
          // ERET outside a handler is reported as a reserved instruction.
          flush_if = 1'b1;
          flush_id = 1'b1;
          epc_d    = pc_id;
          cause_d  = (exc_brk && !exc_ri) ? C_BRK : C_RI;
          exl_d    = 1'b1;
          state_d  = S_REDIRECT;
        end else if (id_valid && !id_stall && sel_found) begin
          flush_if = 1'b1;
          flush_id = 1'b1;
          irq_ack  = irq_sel;
          epc_d    = pc_id;
          cause_d  = C_IRQ;
          exl_d    = 1'b1;
          state_d  = S_REDIRECT;
        end
      end
      S_REDIRECT: begin
        pc_redirect = 1'b1;
        flush_if    = 1'b1;
        state_d     = S_HANDLER;
      end
      S_HANDLER: begin
        if (ex_exc || exc_ri || exc_brk) begin
          df_d     = 1'b1;
          flush_if = 1'b1;
          flush_id = 1'b1;
          flush_ex = ex_exc;
        end else if (eret && !id_stall) begin
          flush_if = 1'b1;
          state_d  = S_RETURN;
        end
      end
      S_RETURN: begin
        pc_redirect = 1'b1;
        pc_target   = epc_q;
        flush_if    = 1'b1;
        exl_d       = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A new edge wins over an ack of the same line in the same cycle.
  assign pend_d = (pend_q & ~irq_ack) | irq_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      epc_q   <= '0;
      cause_q <= '0;
      exl_q   <= 1'b0;
      df_q    <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      exl_q   <= exl_d;
      df_q    <= df_d;
      sync1_q <= irq;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pend_q  <= pend_d;
    end
  end

  assign epc          = epc_q;
  assign cause        = cause_q;
  assign exl          = exl_q;
  assign double_fault = df_q;

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// Bench for exc_irq_ctrl: per-cycle comparison against an event-level model
// plus hand-computed checkpoints along a directed scenario.
`timescale 1ns/1ps
module tb_exc_irq_ctrl;

  localparam int unsigned IRQ_W = 3;
  localparam logic [31:0] VEC = 32'd400;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [IRQ_W-1:0] irq, irq_mask, irq_ack;
  logic id_valid, id_stall, exc_ovf, exc_divz, exc_brk, exc_ri, eret;
  logic [31:0] pc_id, pc_ex, pc_target, epc;
  logic flush_if, flush_id, flush_ex, pc_redirect, exl, double_fault;
  logic [2:0] cause;

  int n_tests = 0;
  int n_fail  = 0;

  exc_irq_ctrl #(.EXC_VEC(VEC), .IRQ_W(IRQ_W)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .irq_mask(irq_mask),
    .id_valid(id_valid), .id_stall(id_stall), .pc_id(pc_id), .pc_ex(pc_ex),
    .exc_ovf(exc_ovf), .exc_divz(exc_divz), .exc_brk(exc_brk),
    .exc_ri(exc_ri), .eret(eret), .flush_if(flush_if), .flush_id(flush_id),
    .flush_ex(flush_ex), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .epc(epc), .cause(cause), .exl(exl), .irq_ack(irq_ack),
    .double_fault(double_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 0 idle, 1 redirect, 2 handler, 3 return
  int          m_mode;
  logic [31:0] m_epc;
  logic [2:0]  m_cause;
  logic        m_exl, m_df;
  logic [IRQ_W-1:0] m_pend;
  logic [IRQ_W-1:0] hist[$];  // sampled irq values, newest first

  task automatic model_reset();
    m_mode = 0; m_epc = '0; m_cause = '0; m_exl = 1'b0; m_df = 1'b0; m_pend = '0;
    hist = '{3'b000, 3'b000, 3'b000};
  endtask

  initial model_reset();

  always @(negedge clk) begin
    logic e_fif, e_fid, e_fex, e_red, fnd;
    logic [31:0] e_tgt;
    logic [IRQ_W-1:0] e_ack, avail;
    int code;
    if (!rst_n) begin
      model_reset();
    end else begin
      e_fif = 0; e_fid = 0; e_fex = 0; e_red = 0; e_tgt = VEC; e_ack = '0;
      case (m_mode)
        0: begin
          avail = m_pend & irq_mask;
          code = 0;
          if (exc_ovf) code = 2;
          else if (exc_divz) code = 3;
          else if (exc_ri) code = 5;
          else if (exc_brk) code = 4;
          else if (eret) code = 5;
          else if (id_valid && !id_stall && avail != '0) code = 1;
          if (code != 0) begin
            e_fif = 1; e_fid = 1; e_fex = (code == 2 || code == 3);
            if (code == 1) begin
              fnd = 0;
              for (int i = 0; i < int'(IRQ_W); i++)
                if (avail[i] && !fnd) begin e_ack[i] = 1'b1; fnd = 1; end
            end
          end
        end
        1: begin e_red = 1; e_fif = 1; end
        2: begin
          if (exc_ovf || exc_divz || exc_ri || exc_brk) begin
            e_fif = 1; e_fid = 1; e_fex = exc_ovf | exc_divz;
          end else if (eret && !id_stall) e_fif = 1;
        end
        default: begin e_red = 1; e_fif = 1; e_tgt = m_epc; end
      endcase
      chk("flush_if", 32'(flush_if), 32'(e_fif));
      chk("flush_id", 32'(flush_id), 32'(e_fid));
      chk("flush_ex", 32'(flush_ex), 32'(e_fex));
      chk("pc_redirect", 32'(pc_redirect), 32'(e_red));
      chk("pc_target", pc_target, e_tgt);
      chk("irq_ack", 32'(irq_ack), 32'(e_ack));
      chk("epc", epc, m_epc);
      chk("cause", 32'(cause), 32'(m_cause));
      chk("exl", 32'(exl), 32'(m_exl));
      chk("double_fault", 32'(double_fault), 32'(m_df));
      // advance model to the state after the coming edge
      case (m_mode)
        0: if (code != 0) begin
          m_epc = (code == 2 || code == 3) ? pc_ex : pc_id;
          m_cause = 3'(code); m_exl = 1; m_mode = 1;
        end
        1: m_mode = 2;
        2: begin
          if (exc_ovf || exc_divz || exc_ri || exc_brk) m_df = 1;
          else if (eret && !id_stall) m_mode = 3;
        end
        default: begin m_exl = 0; m_mode = 0; end
      endcase
      m_pend = (m_pend & ~e_ack) | (hist[1] & ~hist[2]);
      hist.push_front(irq);
      void'(hist.pop_back());
    end
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic mid();  #5; endtask
  task automatic clr_exc();
    exc_ovf = 0; exc_divz = 0; exc_brk = 0; exc_ri = 0; eret = 0;
  endtask
  task automatic do_eret();  // from HANDLER through RETURN into IDLE
    step(); eret = 1;
    step(); eret = 0;
    step();
  endtask

  initial begin
    irq = '0; irq_mask = '0; id_valid = 1; id_stall = 0;
    pc_id = 32'h10; pc_ex = 32'h0c; clr_exc();
    repeat (2) step();
    mid();
    chk("rst pc_target", pc_target, 32'd400);
    chk("rst epc", epc, 32'h0);
    chk("rst exl", 32'(exl), 32'h0);
    step(); rst_n = 1;

    // overflow in EX
    step(); exc_ovf = 1; pc_ex = 32'h20; pc_id = 32'h24;
    mid(); chk("ovf flush_ex", 32'(flush_ex), 32'h1); chk("ovf flush_id", 32'(flush_id), 32'h1);
    step(); exc_ovf = 0;
    mid(); chk("redir", 32'(pc_redirect), 32'h1); chk("redir tgt", pc_target, 32'd400);
    chk("ovf epc", epc, 32'h20); chk("ovf cause", 32'(cause), 32'h2); chk("ovf exl", 32'(exl), 32'h1);
    step(); mid(); chk("handler no redir", 32'(pc_redirect), 32'h0);

    // ERET back to 0x20
    step(); eret = 1; mid(); chk("eret flush_if", 32'(flush_if), 32'h1);
    step(); eret = 0; mid(); chk("ret redir", 32'(pc_redirect), 32'h1); chk("ret tgt", pc_target, 32'h20);
    step(); mid(); chk("ret exl", 32'(exl), 32'h0);

    // divz and brk together: EX wins
    step(); exc_divz = 1; pc_ex = 32'h40; exc_brk = 1; pc_id = 32'h44;
    step(); clr_exc(); mid(); chk("divz cause", 32'(cause), 32'h3); chk("divz epc", epc, 32'h40);
    step(); do_eret(); mid(); chk("cause kept after eret", 32'(cause), 32'h3);

    // irq[1] latency and acceptance
    irq_mask = 3'b011; pc_id = 32'h100;
    step(); irq = 3'b010;
    step(); mid(); chk("irq lat1", 32'(irq_ack), 32'h0);
    step(); mid(); chk("irq lat2", 32'(irq_ack), 32'h0);
    step(); mid(); chk("irq ack", 32'(irq_ack), 32'h2);
    step(); mid(); chk("irq epc", epc, 32'h100); chk("irq cause", 32'(cause), 32'h1);
    step(); do_eret();

    // masked line stays pending until unmasked
    irq = '0; irq_mask = 3'b001;
    repeat (4) step();
    step(); irq = 3'b010;
    repeat (5) step();
    mid(); chk("masked ack", 32'(irq_ack), 32'h0);
    step(); irq_mask = 3'b011; mid(); chk("unmasked ack", 32'(irq_ack), 32'h2);
    step(); irq_mask = 3'b001;
    step(); do_eret();
    irq = '0;

    // irq edge while ERET issued in HANDLER
    repeat (3) step();
    step(); exc_ovf = 1; pc_ex = 32'h80;
    step(); clr_exc();
    step(); irq = 3'b001;
    step();
    step(); eret = 1; pc_id = 32'h200;
    step(); eret = 0; mid(); chk("ret before irq", 32'(irq_ack), 32'h0); chk("ret tgt2", pc_target, 32'h80);
    step(); mid(); chk("irq after ret", 32'(irq_ack), 32'h1);
    step(); step();

    // double fault in HANDLER
    step(); exc_ri = 1; pc_id = 32'h300; mid(); chk("df flush_id", 32'(flush_id), 32'h1);
    step(); exc_ri = 0;
    mid(); chk("df set", 32'(double_fault), 32'h1); chk("df epc", epc, 32'h200); chk("df cause", 32'(cause), 32'h1);
    step(); eret = 1; id_stall = 1; mid(); chk("stalled eret", 32'(flush_if), 32'h0);
    id_stall = 0; eret = 0;
    do_eret(); mid(); chk("df sticky", 32'(double_fault), 32'h1);

    // async reset during REDIRECT
    step(); exc_brk = 1; pc_id = 32'h500;
    step(); clr_exc(); #2; rst_n = 0; irq = '0; #1;
    chk("arst redir", 32'(pc_redirect), 32'h0); chk("arst tgt", pc_target, 32'd400);
    chk("arst epc", epc, 32'h0); chk("arst cause", 32'(cause), 32'h0);
    chk("arst exl", 32'(exl), 32'h0); chk("arst df", 32'(double_fault), 32'h0);
    chk("arst flush", 32'(flush_if), 32'h0);
    step(); rst_n = 1;
    step(); mid(); chk("post rst exl", 32'(exl), 32'h0);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
